alu_share_ctrl: RTL and testbench

Sequencer and arbiter that lets two requesters share the single combinational ALU. It accepts operations with a valid/ready handshake and grants them round-robin. It registers the ALU operands, captures the result and flags, and returns them with a valid/ready response. It keeps a private carry bit per requester and feeds it to the ALU `Cin`, so `ADDC`/`ADDCU` chains from one requester are not disturbed by the other.

---
 rtl/alu_share_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Two-requester sequencer/arbiter in front of one shared
//               combinational ALU. Round-robin grant, registered ALU drive,
//               captured result/flags returned over a valid/ready response,
//               and one private carry bit per requester fed to ALU Cin.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [3:0]       req_exop0,
  input  logic [3:0]       req_exop1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,

  output logic [3:0]       alu_op,
  output logic [3:0]       alu_exop,
  output logic [WIDTH-1:0] alu_rdest,
  output logic [WIDTH-1:0] alu_rsrc,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [4:0]       alu_flags,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic [4:0]       resp_flags
);

  // Sequencer states: IDLE arbitrates, EXEC lets the ALU settle for one
  // cycle, RESP holds the captured result until the consumer takes it.
  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_EXEC = 2'b01;
  localparam logic [1:0] C_RESP = 2'b10;

  logic [1:0]       state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q,      owner_d;
  logic [1:0]       carry_q,      carry_d;
  logic [3:0]       op_q,         op_d;
  logic [3:0]       exop_q,       exop_d;
  logic [WIDTH-1:0] rdest_q,      rdest_d;
  logic [WIDTH-1:0] rsrc_q,       rsrc_d;
  logic             resp_id_q,    resp_id_d;
  logic [WIDTH-1:0] resp_data_q,  resp_data_d;
  logic [4:0]       resp_flags_q, resp_flags_d;

  logic             grant_any;
  logic             grant_idx;
  logic             xfer;
  logic             add_class;

  // Add-class operations are the only ones whose carry-out is remembered.
  function automatic logic is_add_class(input logic [3:0] op, input logic [3:0] exop);
    logic hit;
    hit = 1'b0;
    case (op)
      4'b0000: hit = (exop == 4'b0101) || (exop == 4'b0110) ||
                     (exop == 4'b0111) || (exop == 4'b1010);
      4'b0101, 4'b0110, 4'b0111, 4'b1101: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Round-robin pick: a lone requester wins, on contention the one that was
  // not served last wins.
  always_comb begin
    grant_any = |req_valid;
    grant_idx = 1'b0;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_q;
      default: grant_idx = 1'b0;
    endcase
  end

  // Accept only in IDLE, only the granted requester, never during reset.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == C_IDLE) && !reset && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer      = |(req_valid & req_ready);
  assign add_class = is_add_class(op_q, exop_q);

  // Next-state and datapath capture for the sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    carry_d      = carry_q;
    op_d         = op_q;
    exop_d       = exop_q;
    rdest_d      = rdest_q;
    rsrc_d       = rsrc_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_flags_d = resp_flags_q;

    case (state_q)
      C_IDLE: begin
        if (xfer) begin
          state_d      = C_EXEC;
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          op_d         = grant_idx ? req_op1   : req_op0;
          exop_d       = grant_idx ? req_exop1 : req_exop0;
          rdest_d      = grant_idx ? req_a1    : req_a0;
          rsrc_d       = grant_idx ? req_b1    : req_b0;
        end
      end
      C_EXEC: begin
        // ALU inputs have been stable for a full cycle; take its answer.
        resp_id_d    = owner_q;
        resp_data_d  = alu_out;
        resp_flags_d = alu_flags;
        if (add_class) begin
          carry_d[owner_q] = alu_flags[0];
        end
        state_d = C_RESP;
      end
      C_RESP: begin
        // Returning to IDLE first means no accept in the handshake cycle.
        if (resp_ready) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction and clears both carries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= C_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      carry_q      <= 2'b00;
      op_q         <= 4'd0;
      exop_q       <= 4'd0;
      rdest_q      <= '0;
      rsrc_q       <= '0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_flags_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      carry_q      <= carry_d;
      op_q         <= op_d;
      exop_q       <= exop_d;
      rdest_q      <= rdest_d;
      rsrc_q       <= rsrc_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  assign alu_op     = op_q;
  assign alu_exop   = exop_q;
  assign alu_rdest  = rdest_q;
  assign alu_rsrc   = rsrc_q;
  assign alu_cin    = carry_q[owner_q];

  assign resp_valid = (state_q == C_RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_flags = resp_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Self-checking bench for alu_share_ctrl. Provides a small
//               combinational ALU, a transaction-level reference model and
//               directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_op0, req_op1, req_exop0, req_exop1;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [3:0]   alu_op, alu_exop;
  logic [W-1:0] alu_rdest, alu_rsrc;
  logic         alu_cin;
  logic [W-1:0] alu_out;
  logic [4:0]   alu_flags;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_data;
  logic [4:0]   resp_flags;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_exop0(req_exop0), .req_exop1(req_exop1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .alu_op(alu_op), .alu_exop(alu_exop),
    .alu_rdest(alu_rdest), .alu_rsrc(alu_rsrc), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flags(resp_flags)
  );

  // ---------------- ALU behaviour (environment) ----------------
  function automatic logic is_add(input logic [3:0] op, input logic [3:0] exop);
    return (op == 4'd0 && (exop inside {4'b0101, 4'b0110, 4'b0111, 4'b1010})) ||
           (op inside {4'b0101, 4'b0110, 4'b0111, 4'b1101});
  endfunction

  function automatic logic uses_cin(input logic [3:0] op, input logic [3:0] exop);
    return (op == 4'd0 && (exop inside {4'b0111, 4'b1010})) ||
           (op inside {4'b0111, 4'b1101});
  endfunction

  // Returns {flags[4:0], result[15:0]}
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] exop,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    f    = 5'd0;
    f[4] = $signed(a) < $signed(b);
    f[3] = (a == b);
    if (is_add(op, exop)) begin
      s    = {1'b0, a} + {1'b0, b} + {16'd0, uses_cin(op, exop) & cin};
      r    = s[15:0];
      f[0] = s[16];
      f[2] = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r    = a ^ b;
      f[1] = a < b;
    end
    return {f, r};
  endfunction

  assign {alu_flags, alu_out} = alu_fn(alu_op, alu_exop, alu_rdest, alu_rsrc, alu_cin);

  // ---------------- Reference model (transaction level) ----------------
  bit         m_busy = 0;
  int         m_age  = 0;     // cycles since the accept edge
  logic       m_last = 1'b1;
  logic [1:0] m_carry = 2'b00;
  logic       m_id = 1'b0;
  logic [3:0] m_op = 4'd0, m_exop = 4'd0;
  logic [15:0] m_a = 16'd0, m_b = 16'd0;
  logic       m_resp_id = 1'b0;
  logic [15:0] m_rdata = 16'd0;
  logic [4:0] m_rflags = 5'd0;
  bit         m_acc = 0;
  logic       m_acc_id = 1'b0;

  function automatic int winner();
    if (req_valid == 2'b11) return m_last ? 0 : 1;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    m_acc = 0;
    if (reset) begin
      m_busy = 0; m_age = 0; m_last = 1'b1; m_carry = 2'b00; m_id = 1'b0;
      m_op = 4'd0; m_exop = 4'd0; m_a = 16'd0; m_b = 16'd0;
      m_resp_id = 1'b0; m_rdata = 16'd0; m_rflags = 5'd0;
    end else if (m_busy) begin
      if (m_age == 1) begin
        {m_rflags, m_rdata} = alu_fn(m_op, m_exop, m_a, m_b, m_carry[m_id]);
        m_resp_id = m_id;
        if (is_add(m_op, m_exop)) m_carry[m_id] = m_rflags[0];
        m_age = 2;
      end else if (resp_ready) begin
        m_busy = 0;
      end
    end else begin
      w = winner();
      if (w >= 0) begin
        m_id   = (w == 1);
        m_op   = m_id ? req_op1   : req_op0;
        m_exop = m_id ? req_exop1 : req_exop0;
        m_a    = m_id ? req_a1    : req_a0;
        m_b    = m_id ? req_b1    : req_b0;
        m_last = m_id;
        m_busy = 1; m_age = 1;
        m_acc = 1; m_acc_id = m_id;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial forever begin
    logic [1:0] exp_ready;
    int w;
    @(negedge clk);
    if (reset) begin
      chk("rst req_ready", req_ready, 2'b00);
      chk("rst resp_valid", resp_valid, 1'b0);
      chk("rst resp_id", resp_id, 1'b0);
      chk("rst resp_data", resp_data, 16'd0);
      chk("rst resp_flags", resp_flags, 5'd0);
      chk("rst alu_op", alu_op, 4'd0);
      chk("rst alu_exop", alu_exop, 4'd0);
      chk("rst alu_rdest", alu_rdest, 16'd0);
      chk("rst alu_rsrc", alu_rsrc, 16'd0);
      chk("rst alu_cin", alu_cin, 1'b0);
    end else begin
      exp_ready = 2'b00;
      if (!m_busy) begin
        w = winner();
        if (w >= 0) exp_ready = (w == 1) ? 2'b10 : 2'b01;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("resp_valid", resp_valid, (m_busy && m_age >= 2));
      chk("resp_id", resp_id, m_resp_id);
      chk("resp_data", resp_data, m_rdata);
      chk("resp_flags", resp_flags, m_rflags);
      chk("alu_op", alu_op, m_op);
      chk("alu_exop", alu_exop, m_exop);
      chk("alu_rdest", alu_rdest, m_a);
      chk("alu_rsrc", alu_rsrc, m_b);
      chk("alu_cin", alu_cin, m_carry[m_id]);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic set_req(input logic id, input logic [3:0] op, input logic [3:0] exop,
                         input logic [15:0] a, input logic [15:0] b);
    if (!id) begin
      req_op0 = op; req_exop0 = exop; req_a0 = a; req_b0 = b;
    end else begin
      req_op1 = op; req_exop1 = exop; req_a1 = a; req_b1 = b;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_acc(input logic id);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #1;
      if (m_acc && m_acc_id == id) ok = 1;
    end
    if (!ok) begin
      n_chk++; n_bad++;
      $display("FAIL accept_timeout req%0d: not accepted in 40 cycles", id);
    end
  endtask

  // lat = cycles from the cycle with ready high to the first resp_valid cycle
  task automatic wait_resp(output logic rid, output logic [15:0] d,
                           output logic [4:0] f, output int lat);
    bit ok;
    ok = 0; lat = 0; rid = 1'b0; d = 16'd0; f = 5'd0;
    for (int k = 1; k <= 20 && !ok; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        ok = 1; lat = k; rid = resp_id; d = resp_data; f = resp_flags;
      end
    end
    if (!ok) begin
      n_chk++; n_bad++;
      $display("FAIL resp_timeout: no resp_valid in 20 cycles at %0t", $time);
    end
  endtask

  task automatic run_op(input logic id, input logic [3:0] op, input logic [3:0] exop,
                        input logic [15:0] a, input logic [15:0] b,
                        output logic rid, output logic [15:0] d,
                        output logic [4:0] f, output int lat);
    @(posedge clk); #2;
    resp_ready = 1'b1;
    set_req(id, op, exop, a, b);
    wait_acc(id);
    #1 req_valid[id] = 1'b0;
    wait_resp(rid, d, f, lat);
  endtask

  task automatic rand_req(input logic id);
    logic [3:0] op, exop;
    logic [15:0] a, b;
    op = 4'd0; exop = 4'd0;
    case ($urandom_range(0, 7))
      0: exop = 4'b0101;
      1: exop = 4'b0110;
      2: exop = 4'b0111;
      3: exop = 4'b1010;
      4: exop = 4'b0011;
      5: case ($urandom_range(0, 3))
           0: op = 4'b0101;
           1: op = 4'b0110;
           2: op = 4'b0111;
           default: op = 4'b1101;
         endcase
      default: begin op = 4'($urandom); exop = 4'($urandom); end
    endcase
    a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    b = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
    set_req(id, op, exop, a, b);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    logic rid;
    logic [15:0] d;
    logic [4:0] f;
    int lat;
    bit hold [2];

    reset = 1'b1; resp_ready = 1'b1; req_valid = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0; req_exop0 = 4'd0; req_exop1 = 4'd0;
    req_a0 = 16'd0; req_a1 = 16'd0; req_b0 = 16'd0; req_b1 = 16'd0;
    set_req(1'b0, 4'd0, 4'b0101, 16'd1, 16'd1);
    @(negedge clk);
    chk("reset holds req_ready low", req_ready, 2'b00);
    chk("reset resp_valid", resp_valid, 1'b0);
    @(posedge clk); #2;
    req_valid = 2'b00;
    @(posedge clk); #2;
    reset = 1'b0;

    // Single ADD
    run_op(1'b0, 4'd0, 4'b0101, 16'h0003, 16'h0004, rid, d, f, lat);
    chk("single latency", lat, 2);
    chk("single id", rid, 1'b0);
    chk("single data", d, 16'h0007);
    chk("single flags", f, 5'b10000);

    // Carry chain and isolation
    run_op(1'b0, 4'd0, 4'b1010, 16'hFFFF, 16'h0001, rid, d, f, lat);
    chk("chain1 data", d, 16'h0000);
    chk("chain1 carry", f[0], 1'b1);
    run_op(1'b1, 4'd0, 4'b1010, 16'h0000, 16'h0000, rid, d, f, lat);
    chk("iso req1 id", rid, 1'b1);
    chk("iso req1 data", d, 16'h0000);
    run_op(1'b0, 4'd0, 4'b0011, 16'h00F0, 16'h0FF0, rid, d, f, lat);
    chk("xor data", d, 16'h0F00);
    run_op(1'b0, 4'd0, 4'b1010, 16'h0000, 16'h0000, rid, d, f, lat);
    chk("chain2 data", d, 16'h0001);
    run_op(1'b1, 4'd0, 4'b1010, 16'hFFFF, 16'h0000, rid, d, f, lat);
    chk("iso req1 after xor", d, 16'hFFFF);

    // Backpressure with a pending req1
    @(posedge clk); #2;
    resp_ready = 1'b0;
    set_req(1'b0, 4'd0, 4'b0101, 16'h1234, 16'h1111);
    wait_acc(1'b0);
    #1 req_valid[0] = 1'b0;
    set_req(1'b1, 4'd0, 4'b0101, 16'h0002, 16'h0002);
    wait_resp(rid, d, f, lat);
    chk("bp data", d, 16'h2345);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("bp resp_valid held", resp_valid, 1'b1);
      chk("bp data stable", resp_data, d);
      chk("bp flags stable", resp_flags, f);
      chk("bp id stable", resp_id, rid);
      chk("bp req_ready low", req_ready, 2'b00);
    end
    @(posedge clk); #2;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp no accept in handshake cycle", req_ready, 2'b00);
    @(negedge clk);
    chk("bp pending req1 granted", req_ready, 2'b10);
    wait_acc(1'b1);
    #1 req_valid[1] = 1'b0;
    wait_resp(rid, d, f, lat);
    chk("bp req1 data", d, 16'h0004);

    // Contention from reset: grants alternate starting with requester 0
    @(posedge clk); #2;
    reset = 1'b1;
    set_req(1'b0, 4'd0, 4'b0101, 16'd1, 16'd2);
    set_req(1'b1, 4'd0, 4'b0101, 16'd5, 16'd6);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_resp(rid, d, f, lat);
      chk("contention id", rid, (j % 2 == 1));
      chk("contention data", d, (j % 2 == 1) ? 16'd11 : 16'd3);
    end
    @(posedge clk); #2;
    req_valid = 2'b00;
    @(posedge clk);

    // Reset during EXEC: no response, carries cleared, req1 alone wins
    run_op(1'b0, 4'd0, 4'b1010, 16'hFFFF, 16'h0001, rid, d, f, lat);
    @(posedge clk); #2;
    set_req(1'b0, 4'd0, 4'b1010, 16'h0000, 16'h0000);
    wait_acc(1'b0);
    #1 reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid reset resp_valid", resp_valid, 1'b0);
    set_req(1'b1, 4'd0, 4'b0101, 16'h0010, 16'h0020);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post reset req1 grant", req_ready, 2'b10);
    wait_acc(1'b1);
    #1 req_valid[1] = 1'b0;
    wait_resp(rid, d, f, lat);
    chk("post reset req1 data", d, 16'h0030);
    run_op(1'b0, 4'd0, 4'b1010, 16'h0000, 16'h0000, rid, d, f, lat);
    chk("carry cleared by reset", d, 16'h0000);

    // Randomized traffic
    @(posedge clk); #2;
    req_valid = 2'b00;
    hold[0] = 0; hold[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (hold[i] && m_acc && m_acc_id == (i == 1)) hold[i] = 0;
      end
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            rand_req(i == 1);
            hold[i] = 1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
